lcd_tx_frame_queue: RTL and testbench
=====================================

Name: lcd_tx_frame_queue

Overview:
- Upstream feeder for the UART TX supervisor (88-bit frame, 8-bit byte count, begin/busy/done handshake).
- Buffers up to DEPTH command frames from LCD control logic via valid/ready.
- Issues frames one at a time: single-cycle begin pulse, waits for the supervisor's done pulse before the next launch.
- Lets producers queue bursts of LCD commands without tracking UART timing.

Parameters:
- DEPTH, 4, number of queued frames; power of two, 2..16.
- MAX_BYTES, 11, largest legal byte count per frame; the frame width is 88 bits.
- GAP_CYCLES, 16, idle clocks inserted after each frame's done pulse; used only with the optional feature.

Ports:
- i_clock  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous reset, active-high.
- i_frameValid  in  1  producer offers a frame this cycle.
- i_frameData  in  88  frame bytes; byte k (1-based, sent first when k = length) is at bits [8k-1 -: 8].
- i_frameLength  in  8  byte count of the offered frame.
- o_frameReady  out  1  queue can accept a frame this cycle.
- o_frameError  out  1  one-cycle pulse when an illegal-length frame is consumed.
- o_count  out  $clog2(DEPTH)+1  frames currently stored.
- o_idle  out  1  queue empty, FSM in IDLE, supervisor not busy.
- o_txBegin  out  1  begin pulse to the supervisor.
- o_txData  out  88  frame data to the supervisor.
- o_txDataLength  out  8  byte count to the supervisor.
- i_txBusy  in  1  supervisor busy.
- i_txDone  in  1  supervisor one-cycle done pulse.

Behaviour:
- Reset: asynchronous, active-high; all registers clear while i_reset=1.
  - Outputs during and after reset: o_txBegin=0, o_txData=0, o_txDataLength=0, o_frameError=0, o_count=0, o_frameReady=1.
  - o_idle = 1 if i_txBusy=0.
- Push:
  - A handshake occurs when i_frameValid && o_frameReady.
  - o_frameReady = (count != DEPTH); it uses the registered count only. A pop in the same cycle does not raise ready.
  - Legal length is 1..MAX_BYTES. A legal frame is written at the write pointer, and the count increments next cycle.
  - Length 0 or >MAX_BYTES: the frame is consumed but not stored, and o_frameError pulses 1 on the next cycle.
- Storage:
  - Circular buffer of DEPTH entries of {length, data}.
  - Read and write pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leave the count unchanged.
- FSM states: IDLE, WAIT_BUSY, WAIT_DONE (plus GAP, only when the optional feature is compiled in).
  - IDLE: when count>0 and i_txBusy=0:
    - Register the head entry onto o_txData/o_txDataLength.
    - Set o_txBegin=1 and pop the entry.
    - Move to WAIT_BUSY.
  - WAIT_BUSY:
    - o_txBegin returns to 0 on the next clock, so the pulse is exactly one cycle.
    - When i_txBusy=1, move to WAIT_DONE.
  - WAIT_DONE: on i_txDone=1, move to IDLE.
- Launch latency and spacing:
  - A push into an empty, idle queue produces o_txBegin 2 cycles after the push edge.
  - IDLE re-checks i_txBusy, which stays high in the cycle the done pulse is seen. Back-to-back launches are therefore at least 2 cycles after done.
- o_txData and o_txDataLength hold their values until the next launch.
- Simultaneous events:
  - i_txDone seen while in WAIT_BUSY: move straight to IDLE, with no hang.
  - i_txDone seen while in IDLE: ignored.
- Reset mid-frame:
  - Queue contents are discarded and the FSM returns to IDLE.
  - The supervisor is not reset by this block. After reset, the first launch waits for i_txBusy=0.

Optional Feature:
- Macro: LCD_TX_QUEUE_GAP_EN.
- Defined:
  - WAIT_DONE moves to GAP on done.
  - GAP counts GAP_CYCLES clocks, then moves to IDLE. This gives the LCD settling time.
  - A GAP_CYCLES value of 0 behaves as undefined.
- Undefined:
  - No GAP state and no counter logic.
  - WAIT_DONE moves directly to IDLE.

Test Plan:
- Single frame: push length=3, data[23:0]=0x414243 into an empty queue.
  - o_txBegin pulses 1 cycle, 2 cycles after the push, with o_txDataLength=3 and o_txData[23:0]=0x414243.
  - o_count goes 1 then 0.
  - After the supervisor model's done, o_idle=1.
- Fill/full: push 5 frames back-to-back, DEPTH=4, with the supervisor model stalled busy.
  - o_frameReady=0 after the 4th push; the 5th is held until the first launch plus one cycle.
  - Frames are emitted in order 1..5.
- Illegal length: push length=0, then length=12.
  - Each produces an o_frameError pulse and no o_txBegin; o_count stays 0.
  - o_frameReady stays 1.
- Back-to-back: queue 3 frames (lengths 1, 11, 2).
  - Exactly 3 begin pulses, each strictly after the prior done and with i_txBusy=0.
  - Lengths arrive in order 1, 11, 2.
- Reset mid-operation: 3 frames queued, assert i_reset during WAIT_DONE.
  - Outputs clear immediately and o_count=0.
  - After release, a new push launches only once i_txBusy=0.
- With LCD_TX_QUEUE_GAP_EN defined and GAP_CYCLES=16: two queued frames.
  - The second o_txBegin is at least 17 cycles after the first done.
  - Without the macro, it is 2 cycles after done.

Source files
------------

// File: rtl/lcd_tx_frame_queue_if.sv
// Frame-producer and TX-supervisor signals of lcd_tx_frame_queue, grouped as one bundle.
// The slave modport is the queue itself; master is the surrounding logic.
interface lcd_tx_frame_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          i_frameValid;
    logic [87:0]   i_frameData;
    logic [7:0]    i_frameLength;
    logic          o_frameReady;
    logic          o_frameError;
    logic [CW-1:0] o_count;
    logic          o_idle;
    logic          o_txBegin;
    logic [87:0]   o_txData;
    logic [7:0]    o_txDataLength;
    logic          i_txBusy;
    logic          i_txDone;

    modport slave (
        input  i_frameValid, i_frameData, i_frameLength, i_txBusy, i_txDone,
        output o_frameReady, o_frameError, o_count, o_idle,
               o_txBegin, o_txData, o_txDataLength
    );

    modport master (
        output i_frameValid, i_frameData, i_frameLength, i_txBusy, i_txDone,
        input  o_frameReady, o_frameError, o_count, o_idle,
               o_txBegin, o_txData, o_txDataLength
    );
endinterface

// File: rtl/lcd_tx_frame_queue.sv
// DEPTH-entry LCD command-frame FIFO feeding the UART TX supervisor one frame at a time.
// Define LCD_TX_QUEUE_GAP_EN to insert GAP_CYCLES idle clocks after every done pulse.
module lcd_tx_frame_queue #(
    parameter int DEPTH      = 4,
    parameter int MAX_BYTES  = 11,
    parameter int GAP_CYCLES = 16
) (
    input logic                 i_clock,
    input logic                 i_reset,
    lcd_tx_frame_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 ||
        MAX_BYTES < 1 || MAX_BYTES > 11 || GAP_CYCLES < 0) begin : g_badParams
        $error("lcd_tx_frame_queue: unsupported parameter combination");
    end

`ifdef LCD_TX_QUEUE_GAP_EN
    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE, GAP} state_e;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    logic [GW-1:0] gapCnt_q, gapCnt_d;
`else
    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_e;
`endif

    state_e        state_q, state_d;
    logic [95:0]   mem_q [DEPTH];
    logic [PW-1:0] wrPtr_q, rdPtr_q;
    logic [CW-1:0] count_q;
    logic          txBegin_q, txBegin_d;
    logic [87:0]   txData_q, txData_d;
    logic [7:0]    txLen_q, txLen_d;
    logic          frameError_q;
    logic          push, legal, store, pop;

    // Ready looks only at the registered count, so a same-cycle pop never opens a slot.
    assign bus.o_frameReady = (count_q != CW'(DEPTH));
    assign push  = bus.i_frameValid && bus.o_frameReady;
    assign legal = (bus.i_frameLength != 8'd0) && (bus.i_frameLength <= 8'(MAX_BYTES));
    assign store = push && legal;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wrPtr_q      <= '0;
            rdPtr_q      <= '0;
            count_q      <= '0;
            frameError_q <= 1'b0;
        end else begin
            if (store) begin
                mem_q[wrPtr_q] <= {bus.i_frameLength, bus.i_frameData};
                wrPtr_q        <= wrPtr_q + 1'b1;
            end
            if (pop) rdPtr_q <= rdPtr_q + 1'b1;
            count_q      <= count_q + CW'(store) - CW'(pop);
            frameError_q <= push && !legal;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= IDLE;
            txBegin_q <= 1'b0;
            txData_q  <= '0;
            txLen_q   <= '0;
`ifdef LCD_TX_QUEUE_GAP_EN
            gapCnt_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            txBegin_q <= txBegin_d;
            txData_q  <= txData_d;
            txLen_q   <= txLen_d;
`ifdef LCD_TX_QUEUE_GAP_EN
            gapCnt_q  <= gapCnt_d;
`endif
        end
    end

    // IDLE insists on a non-busy supervisor, which also covers a supervisor left running across our reset.
    always_comb begin
        state_d   = state_q;
        txBegin_d = 1'b0;
        txData_d  = txData_q;
        txLen_d   = txLen_q;
        pop       = 1'b0;
`ifdef LCD_TX_QUEUE_GAP_EN
        gapCnt_d  = gapCnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (count_q != '0 && !bus.i_txBusy) begin
                    {txLen_d, txData_d} = mem_q[rdPtr_q];
                    txBegin_d = 1'b1;
                    pop       = 1'b1;
                    state_d   = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (bus.i_txDone)      state_d = IDLE;
                else if (bus.i_txBusy) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (bus.i_txDone) begin
`ifdef LCD_TX_QUEUE_GAP_EN
                    if (GAP_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d  = GAP;
                        gapCnt_d = '0;
                    end
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef LCD_TX_QUEUE_GAP_EN
            GAP: begin
                if (gapCnt_q == GW'(GAP_CYCLES - 1)) state_d = IDLE;
                else                                 gapCnt_d = gapCnt_q + 1'b1;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign bus.o_txBegin      = txBegin_q;
    assign bus.o_txData       = txData_q;
    assign bus.o_txDataLength = txLen_q;
    assign bus.o_frameError   = frameError_q;
    assign bus.o_count        = count_q;
    assign bus.o_idle         = (count_q == '0) && (state_q == IDLE) && !bus.i_txBusy;
endmodule

// File: tb/tb_lcd_tx_frame_queue.sv
// Directed bench for lcd_tx_frame_queue: a supervisor model answers each begin pulse,
// and a scoreboard of pushed frames is checked against every launch.
module tb_lcd_tx_frame_queue;
    localparam int DEPTH     = 4;
    localparam int MAX_BYTES = 11;
`ifdef LCD_TX_QUEUE_GAP_EN
    localparam int EXP_SPACING = 18;
`else
    localparam int EXP_SPACING = 2;
`endif

    logic clock = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;
    int   cycleCnt = 0;
    int   lastPushCycle = 0;
    int   lastBeginCycle = 0;
    int   lastDoneCycle = 0;
    int   beginCount = 0;
    int   holdCycles = 3;
    int   supTimer = 0;
    bit   supBusy = 0;
    bit   supDone = 0;
    bit   forceBusy = 0;
    bit   checkSpacing = 0;
    bit   spacingArmed = 0;
    logic [95:0] sb [$];

    lcd_tx_frame_queue_if #(.DEPTH(DEPTH)) bus ();

    lcd_tx_frame_queue #(
        .DEPTH(DEPTH), .MAX_BYTES(MAX_BYTES), .GAP_CYCLES(16)
    ) dut (
        .i_clock(clock),
        .i_reset(reset),
        .bus(bus.slave)
    );

    assign bus.i_txBusy = forceBusy | supBusy;
    assign bus.i_txDone = supDone;

    always #5 clock = ~clock;

    always @(posedge clock) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string tag, input logic [95:0] observed, input logic [95:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h required %0h", tag, observed, expected);
        end
    endtask

    // Offer one frame and hold it until the queue takes it; legal frames join the scoreboard.
    task automatic applyStimulus(input logic [7:0] len, input logic [87:0] data);
        bit accepted = 0;
        @(negedge clock);
        bus.i_frameValid  = 1'b1;
        bus.i_frameData   = data;
        bus.i_frameLength = len;
        for (int i = 0; i < 200; i++) begin
            if (bus.o_frameReady) begin
                accepted = 1;
                break;
            end
            @(negedge clock);
        end
        vectors++;
        assert (accepted) else begin
            miscompares++;
            $error("FAIL push_accept: observed no handshake in 200 cycles, required a handshake");
        end
        if (accepted) begin
            lastPushCycle = cycleCnt;
            if (len >= 8'd1 && len <= 8'(MAX_BYTES)) sb.push_back({len, data});
            @(posedge clock);
            #1;
        end
        bus.i_frameValid = 1'b0;
    endtask

    task automatic waitDrain(input int maxCycles);
        bit drained = 0;
        for (int i = 0; i < maxCycles; i++) begin
            @(negedge clock);
            if (sb.size() == 0 && bus.o_idle) begin
                drained = 1;
                break;
            end
        end
        vectors++;
        assert (drained) else begin
            miscompares++;
            $error("FAIL drain: observed %0d frames still pending or not idle, required empty and idle", sb.size());
        end
    endtask

    // Launch monitor first, then the supervisor model: busy one cycle after begin,
    // done after holdCycles with busy still high, busy drops with done.
    always @(negedge clock) begin
        logic [95:0] exp;
        if (!reset && bus.o_txBegin) begin
            beginCount++;
            lastBeginCycle = cycleCnt;
            vectors++;
            assert (sb.size() > 0) else begin
                miscompares++;
                $error("FAIL begin_unexpected: observed a begin pulse, required none (scoreboard empty)");
            end
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                checkOutput("tx_length", {88'd0, bus.o_txDataLength}, {88'd0, exp[95:88]});
                checkOutput("tx_data", {8'd0, bus.o_txData}, {8'd0, exp[87:0]});
            end
            checkOutput("busy_at_begin", {95'd0, bus.i_txBusy}, 96'd0);
            if (checkSpacing && spacingArmed)
                checkOutput("launch_spacing", 96'(cycleCnt - lastDoneCycle), 96'(EXP_SPACING));
            spacingArmed = 0;
        end
        if (supDone) begin
            supDone = 0;
            supBusy = 0;
        end else if (supBusy) begin
            if (supTimer == 0) begin
                supDone       = 1;
                lastDoneCycle = cycleCnt;
                spacingArmed  = 1;
            end else begin
                supTimer--;
            end
        end
        if (!reset && bus.o_txBegin) begin
            supBusy  = 1;
            supTimer = holdCycles;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish by 200us, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int beginsBefore;
        int firstBegin;
        logic [87:0] d88;

        bus.i_frameValid  = 1'b0;
        bus.i_frameData   = '0;
        bus.i_frameLength = '0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checkOutput("rst_begin",  {95'd0, bus.o_txBegin}, 96'd0);
        checkOutput("rst_data",   {8'd0, bus.o_txData}, 96'd0);
        checkOutput("rst_length", {88'd0, bus.o_txDataLength}, 96'd0);
        checkOutput("rst_error",  {95'd0, bus.o_frameError}, 96'd0);
        checkOutput("rst_count",  96'(bus.o_count), 96'd0);
        checkOutput("rst_ready",  {95'd0, bus.o_frameReady}, 96'd1);
        checkOutput("rst_idle",   {95'd0, bus.o_idle}, 96'd1);
        reset = 1'b0;

        $display("[TB] single frame");
        applyStimulus(8'd3, 88'h414243);
        @(negedge clock);
        checkOutput("single_count1", 96'(bus.o_count), 96'd1);
        checkOutput("single_nobegin", {95'd0, bus.o_txBegin}, 96'd0);
        @(negedge clock);
        checkOutput("single_begin", {95'd0, bus.o_txBegin}, 96'd1);
        checkOutput("single_latency", 96'(cycleCnt - lastPushCycle), 96'd2);
        checkOutput("single_len", {88'd0, bus.o_txDataLength}, 96'd3);
        checkOutput("single_data", {72'd0, bus.o_txData[23:0]}, 96'h414243);
        checkOutput("single_count0", 96'(bus.o_count), 96'd0);
        @(negedge clock);
        checkOutput("single_pulse_end", {95'd0, bus.o_txBegin}, 96'd0);
        waitDrain(100);
        checkOutput("single_idle", {95'd0, bus.o_idle}, 96'd1);
        checkOutput("single_len_held", {88'd0, bus.o_txDataLength}, 96'd3);

        $display("[TB] fill and full");
        forceBusy = 1;
        for (int k = 1; k <= 4; k++) begin
            d88 = {$urandom, $urandom, $urandom};
            applyStimulus(8'(k), d88);
        end
        @(negedge clock);
        checkOutput("full_ready", {95'd0, bus.o_frameReady}, 96'd0);
        checkOutput("full_count", 96'(bus.o_count), 96'd4);
        firstBegin = beginCount;
        fork
            applyStimulus(8'd5, 88'h55_5555);
            begin
                repeat (2) @(negedge clock);
                forceBusy = 0;
            end
        join
        checkOutput("full_fifth_cycle", 96'(lastPushCycle), 96'(lastBeginCycle));
        checkOutput("full_one_launch", 96'(beginCount - firstBegin), 96'd1);
        waitDrain(300);

        $display("[TB] illegal lengths");
        beginsBefore = beginCount;
        applyStimulus(8'd0, 88'hDEAD);
        @(negedge clock);
        checkOutput("len0_error", {95'd0, bus.o_frameError}, 96'd1);
        checkOutput("len0_count", 96'(bus.o_count), 96'd0);
        checkOutput("len0_ready", {95'd0, bus.o_frameReady}, 96'd1);
        @(negedge clock);
        checkOutput("len0_error_pulse", {95'd0, bus.o_frameError}, 96'd0);
        applyStimulus(8'd12, 88'hBEEF);
        @(negedge clock);
        checkOutput("len12_error", {95'd0, bus.o_frameError}, 96'd1);
        checkOutput("len12_count", 96'(bus.o_count), 96'd0);
        repeat (4) @(negedge clock);
        checkOutput("illegal_no_begin", 96'(beginCount - beginsBefore), 96'd0);

        $display("[TB] back-to-back");
        checkSpacing = 1;
        spacingArmed = 0;
        beginsBefore = beginCount;
        applyStimulus(8'd1, 88'hA1);
        applyStimulus(8'd11, 88'h0102_0304_0506_0708_090A_0B);
        applyStimulus(8'd2, 88'hB2C3);
        waitDrain(300);
        checkOutput("b2b_begins", 96'(beginCount - beginsBefore), 96'd3);
        checkSpacing = 0;

        $display("[TB] reset mid-frame");
        holdCycles = 20;
        applyStimulus(8'd4, 88'h1111_2222);
        applyStimulus(8'd5, 88'h33_4444_5555);
        applyStimulus(8'd6, 88'h6666_7777_8888);
        for (int i = 0; i < 50 && !supBusy; i++) @(negedge clock);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        #1;
        sb.delete();
        checkOutput("mid_rst_begin", {95'd0, bus.o_txBegin}, 96'd0);
        checkOutput("mid_rst_data", {8'd0, bus.o_txData}, 96'd0);
        checkOutput("mid_rst_length", {88'd0, bus.o_txDataLength}, 96'd0);
        checkOutput("mid_rst_count", 96'(bus.o_count), 96'd0);
        checkOutput("mid_rst_ready", {95'd0, bus.o_frameReady}, 96'd1);
        checkOutput("mid_rst_idle_busy", {95'd0, bus.o_idle}, 96'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        holdCycles = 3;
        applyStimulus(8'd7, 88'h77);
        repeat (2) @(negedge clock);
        checkOutput("post_rst_held", 96'(bus.o_count), 96'd1);
        waitDrain(200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
